// File: rtl/tlul_sram_responder.sv
// TL-UL device endpoint that turns A-channel Get/Put requests into single-port SRAM
// accesses and returns in-order D-channel responses through a small tracking FIFO.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_sram_responder #(
  parameter int SramAw      = 10,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic [31:0]       rdata_i
);

  localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CntW = $clog2(Outstanding + 1);

  typedef struct packed {
    logic        rsp_op;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic        is_read;
    logic        has_data;
    logic [31:0] data;
  } entry_t;

  entry_t            fifo_q [Outstanding];
  logic [PtrW-1:0]   wptr_q, rptr_q, rd_idx_q;
  logic [CntW-1:0]   count_q;
  logic              rd_pend_q;

  logic a_ready, accept, push, pop, is_get, err, good;
  logic op_err, size_err, align_err, range_err, pfd_err;
  logic bypass, d_valid;
  entry_t new_entry, head;
  logic unused_sig;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_sig = ^{tl_i.a_param, tl_i.a_user};

  assign a_ready = (count_q < CntW'(Outstanding));
  assign accept  = tl_i.a_valid && a_ready;
  assign is_get  = (tl_i.a_opcode == 3'd4);

  always_comb begin
    op_err    = !(tl_i.a_opcode == 3'd0 || tl_i.a_opcode == 3'd1 || is_get);
    size_err  = (tl_i.a_size > 2'd2);
    align_err = (tl_i.a_size == 2'd1 && tl_i.a_address[0]) ||
                (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'b00);
    range_err = (tl_i.a_address[31:SramAw+2] != '0);
    pfd_err   = (tl_i.a_opcode == 3'd0) && (tl_i.a_size != 2'd2 || tl_i.a_mask != 4'hF);
    err       = op_err || size_err || align_err || range_err || pfd_err;
  end

  assign good = accept && !err;
  assign push = accept;

  // Gated by rst_ni so the strobe falls the instant reset is asserted.
  assign req_o   = rst_ni && good;
  assign we_o    = req_o && !is_get;
  assign addr_o  = req_o ? tl_i.a_address[SramAw+1:2] : '0;
  assign wdata_o = req_o ? tl_i.a_data : '0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign wmask_o[8*gi +: 8] = {8{req_o && tl_i.a_mask[gi]}};
  end

  always_comb begin
    new_entry          = '0;
    new_entry.rsp_op   = is_get;
    new_entry.size     = tl_i.a_size;
    new_entry.source   = tl_i.a_source;
    new_entry.error    = err;
    new_entry.is_read  = is_get;
    new_entry.has_data = err || !is_get;
  end

  assign head = fifo_q[rptr_q];
  // Read data arrives the cycle after the access; forward it so a read answers at accept+1.
  assign bypass  = rd_pend_q && (rd_idx_q == rptr_q);
  assign d_valid = (count_q != '0) && (head.has_data || bypass);
  assign pop     = d_valid && tl_i.d_ready;

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    if (d_valid) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = {2'b00, head.rsp_op};
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_error  = head.error;
      if (head.is_read) begin
        if (head.error)         tl_o.d_data = 32'hFFFF_FFFF;
        else if (head.has_data) tl_o.d_data = head.data;
        else                    tl_o.d_data = rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
      for (int i = 0; i < Outstanding; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= new_entry;
        wptr_q         <= ptr_inc(wptr_q);
      end
      // The slot being captured is never the one pushed this cycle.
      if (rd_pend_q) begin
        fifo_q[rd_idx_q].data     <= rdata_i;
        fifo_q[rd_idx_q].has_data <= 1'b1;
      end
      rd_pend_q <= good && is_get;
      rd_idx_q  <= wptr_q;
      if (pop) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule
